// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - instruction field positions shared by the fetch stage
package if_fetch_stage_pkg;

  // Opcode and function-code bit positions within a 16-bit TSC instruction
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;

  localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
  localparam int FUNC_W    = FUNC_HI - FUNC_LO + 1;
  localparam int COUNT_W   = 16;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch stage memory, hazard, redirect and IF/ID signal bundle
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int WORD_W = 16
);

  logic [WORD_W-1:0]   i_addr;
  logic                i_read;
  logic [WORD_W-1:0]   i_data;
  logic                i_ready;
  logic                stall;
  logic                redirect_valid;
  logic [WORD_W-1:0]   redirect_pc;
  logic                halt;
  logic [WORD_W-1:0]   ifid_inst;
  logic [WORD_W-1:0]   ifid_pc_next;
  logic                ifid_valid;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func_code;
  logic [COUNT_W-1:0]  fetch_count;

  // The fetch stage drives the memory request and the IF/ID outputs
  modport master (
    output i_addr, i_read, ifid_inst, ifid_pc_next, ifid_valid,
           opcode, func_code, fetch_count,
    input  i_data, i_ready, stall, redirect_valid, redirect_pc, halt
  );

  // Memory, hazard unit and decode side
  modport slave (
    input  i_addr, i_read, ifid_inst, ifid_pc_next, ifid_valid,
           opcode, func_code, fetch_count,
    output i_data, i_ready, stall, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/if_fetch_stage_if_id_register.sv
// rtl/if_fetch_stage_if_id_register.sv - IF/ID pipeline register with load/hold/flush
module if_id_register #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              invalidate_i,
  input  logic [WORD_W-1:0] inst_i,
  input  logic [WORD_W-1:0] pc_next_i,
  output logic [WORD_W-1:0] inst_o,
  output logic [WORD_W-1:0] pc_next_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] inst_q;
  logic [WORD_W-1:0] pc_next_q;
  logic              valid_q;

  // Flush inserts a zero bubble, load captures a new instruction, invalidate
  // only drops valid (halt), otherwise everything holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      inst_q    <= inst_i;
      pc_next_q <= pc_next_i;
      valid_q   <= 1'b1;
    end else if (invalidate_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign inst_o    = inst_q;
  assign pc_next_o = pc_next_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - TSC instruction fetch stage: PC, request FSM, stall buffer
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              WORD_W   = 16,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_stage_if.master bus
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_BUF  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  pc_q, pc_d;
  logic [WORD_W-1:0]  buf_inst_q, buf_inst_d;
  logic [WORD_W-1:0]  buf_pc_next_q, buf_pc_next_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               ifid_flush;
  logic               ifid_load;
  logic               ifid_inval;
  logic [WORD_W-1:0]  ifid_inst_in;
  logic [WORD_W-1:0]  ifid_pc_next_in;
  logic [WORD_W-1:0]  pc_inc;

  assign pc_inc = pc_q + {{(WORD_W-1){1'b0}}, 1'b1};

  // Next-state selection; HALT is sticky, then redirect > halt > stall > normal
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_inst_d      = buf_inst_q;
    buf_pc_next_d   = buf_pc_next_q;
    count_d         = count_q;
    ifid_flush      = 1'b0;
    ifid_load       = 1'b0;
    ifid_inval      = 1'b0;
    ifid_inst_in    = bus.i_data;
    ifid_pc_next_in = pc_inc;
    if (state_q == ST_HALT) begin
      ifid_inval = 1'b1;
    end else if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      ifid_flush = 1'b1;
      state_d    = ST_REQ;
    end else if (bus.halt) begin
      state_d    = ST_HALT;
      ifid_inval = 1'b1;
    end else if (bus.stall) begin
      if (state_q == ST_REQ && bus.i_ready) begin
        buf_inst_d    = bus.i_data;
        buf_pc_next_d = pc_inc;
        state_d       = ST_BUF;
      end
    end else if (state_q == ST_BUF) begin
      ifid_load       = 1'b1;
      ifid_inst_in    = buf_inst_q;
      ifid_pc_next_in = buf_pc_next_q;
      pc_d            = pc_inc;
      count_d         = count_q + 16'd1;
      state_d         = ST_REQ;
    end else if (bus.i_ready) begin
      ifid_load = 1'b1;
      pc_d      = pc_inc;
      count_d   = count_q + 16'd1;
    end else begin
      ifid_flush = 1'b1;
    end
  end

  // PC, FSM state, stall buffer and fetch counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      buf_inst_q    <= '0;
      buf_pc_next_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_next_q <= buf_pc_next_d;
      count_q       <= count_d;
    end
  end

  if_id_register #(.WORD_W(WORD_W)) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (ifid_flush),
    .load_i       (ifid_load),
    .invalidate_i (ifid_inval),
    .inst_i       (ifid_inst_in),
    .pc_next_i    (ifid_pc_next_in),
    .inst_o       (bus.ifid_inst),
    .pc_next_o    (bus.ifid_pc_next),
    .valid_o      (bus.ifid_valid)
  );

  assign bus.i_addr      = pc_q;
  assign bus.i_read      = (state_q == ST_REQ);
  assign bus.opcode      = bus.ifid_inst[OPCODE_HI:OPCODE_LO];
  assign bus.func_code   = bus.ifid_inst[FUNC_HI:FUNC_LO];
  assign bus.fetch_count = count_q;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined TSC CPU: owns the PC, requests instructions from instruction memory over a ready handshake, and holds the IF/ID pipeline register whose opcode/func_code fields feed `control_unit` and `alu_control_unit` directly. It absorbs load-use stalls from the hazard logic, applies branch/jump redirects resolved downstream, and stops fetching when decode reports HLT.

## Interface
- `WORD_W`, 16: instruction/PC width.
- `RESET_PC`, 16'h0000: PC value after reset.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_addr`  out  WORD_W  instruction address; equals `pc`.
- `i_read`  out  1  memory request; high only in state REQ.
- `i_data`  in  WORD_W  instruction word; valid when `i_ready`.
- `i_ready`  in  1  response for the `i_addr` presented this cycle.
- `stall`  in  1  hold IF/ID and PC (hazard unit).
- `redirect_valid`  in  1  taken branch/jump/JPR/JRL resolved downstream.
- `redirect_pc`  in  WORD_W  new fetch target.
- `halt`  in  1  decode has an HLT in ID.
- `ifid_inst`  out  WORD_W  registered instruction.
- `ifid_pc_next`  out  WORD_W  registered PC+1 of that instruction (for JAL/JRL link, branch base).
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `opcode`  out  4  `ifid_inst[15:12]`.
- `func_code`  out  6  `ifid_inst[5:0]`.
- `fetch_count`  out  16  number of instructions loaded into IF/ID.

## Operation
- States: REQ (request outstanding), BUF (one response captured while stalled), HALT.
- Reset: `pc`=RESET_PC, state REQ, `ifid_inst`=0, `ifid_pc_next`=0, `ifid_valid`=0, `fetch_count`=0, buffer empty. `i_read`=1 immediately after reset release.
- Priority each cycle: reset > redirect_valid > halt > stall > normal.
- Redirect: `pc`<=`redirect_pc`; `ifid_valid`<=0, `ifid_inst`<=0; buffer discarded; any same-cycle `i_ready` response discarded; state<=REQ (also leaves BUF). Redirect overrides simultaneous `halt` (the HLT is wrong-path).
- Halt (no redirect): state<=HALT; `ifid_valid`<=0; `pc` frozen; `i_read`=0. HALT exits only by reset.
- REQ, `i_ready`, no stall: IF/ID<={`i_data`, `pc`+1, valid=1}; `pc`<=`pc`+1; `fetch_count`+=1.
- REQ, `i_ready`, stall: buffer<={`i_data`, `pc`+1}; `pc` unchanged; state<=BUF; IF/ID held.
- REQ, no `i_ready`, no stall: bubble: `ifid_valid`<=0, `ifid_inst`<=0.
- REQ or BUF, stall: IF/ID and `pc` held unchanged.
- BUF, no stall: IF/ID<=buffer, valid=1; `pc`<=`pc`+1; `fetch_count`+=1; state<=REQ.
- `i_read`=0 in BUF and HALT.
- Arithmetic: PC increment and `fetch_count` are modulo 2^16; `pc`=16'hFFFF wraps to 0.
- Bubble `ifid_inst`=0 decodes as opcode 0; downstream must gate all side effects with `ifid_valid`.

## Timing
- `i_ready` to `ifid_valid`: 1 cycle. Zero-wait memory sustains one instruction per cycle.
- Redirect asserted in cycle N: `i_addr`=`redirect_pc` in N+1; first target instruction in IF/ID at end of N+1 (zero-wait).
- Stall release from BUF: buffered instruction in IF/ID next edge; new request issued the following cycle.
- `opcode`/`func_code` are pure slices of the register, zero added latency.
- Reset asserted mid-operation: all state returns to reset values asynchronously; buffered and in-flight data lost.

## Structure
- Instruction field positions (opcode [15:12], func [5:0]) as constants in `opcodes.v`; state encoding local to the module.
- One natural sub-module: `if_id_register` (IF/ID storage with load/hold/flush controls); PC, FSM and buffer in the top.

## Test plan
- Reset release, zero-wait memory returning 16'hF01C, 16'h4001: `ifid_inst` = F01C then 4001 on consecutive cycles, `ifid_pc_next` = 1 then 2, `fetch_count`=2.
- `stall` high 3 cycles with `i_ready` high at pc=5: BUF entered, `i_read` low, IF/ID unchanged; on release IF/ID gets pc-5 word, `ifid_pc_next`=6, then `i_addr`=6.
- `redirect_valid`, `redirect_pc`=16'h0040 while `i_ready` at pc=7: pc-7 word dropped, `ifid_valid`=0, next `i_addr`=0040.
- `halt` and `redirect_valid` same cycle: redirect taken, not HALT; `halt` alone: `i_read`=0 and pc frozen for 20 cycles until reset.
- `i_ready` low 2 cycles: two bubbles, `ifid_valid`=0, `ifid_inst`=0, `fetch_count` unchanged.
- `pc`=16'hFFFF fetch: `ifid_pc_next`=0, next `i_addr`=0; reset asserted during BUF clears to RESET_PC.
